// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory port arbiter:
// default word width and FSM state encodings.
package mem_port_arbiter_pkg;

    localparam int WORD_SIZE = 32;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_ACCESS = 2'd1,
        ARB_DONE   = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares the single memory port between instruction fetch and data access.
// One access at a time, fixed latency, alternating grant on contention.
module mem_port_arbiter #(
    parameter int WORD_SIZE   = mem_port_arbiter_pkg::WORD_SIZE,
    parameter int MEM_LATENCY = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 if_req,
    input  logic [WORD_SIZE-1:0] if_addr,
    output logic                 if_done,
    output logic [WORD_SIZE-1:0] if_rdata,
    input  logic                 dm_req,
    input  logic                 dm_w,
    input  logic [WORD_SIZE-1:0] dm_addr,
    input  logic [WORD_SIZE-1:0] dm_wdata,
    output logic                 dm_done,
    output logic [WORD_SIZE-1:0] dm_rdata,
    output logic                 mem_on,
    output logic                 mem_w,
    output logic [WORD_SIZE-1:0] mem_addr,
    output logic [WORD_SIZE-1:0] mem_data_in,
    input  logic [WORD_SIZE-1:0] mem_data_out,
    output logic                 busy,
    output logic                 grant_dm
);

    import mem_port_arbiter_pkg::*;

    localparam int CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(MEM_LATENCY - 1);

    arb_state_t           state_q;
    arb_state_t           state_d;
    logic [CW-1:0]        cnt_q;
    logic                 owner_q;
    logic                 w_q;
    logic                 last_dm_q;
    logic [WORD_SIZE-1:0] addr_q;
    logic [WORD_SIZE-1:0] wdata_q;
    logic [WORD_SIZE-1:0] if_rdata_q;
    logic [WORD_SIZE-1:0] dm_rdata_q;
    logic                 grant;
    logic                 pick_dm;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // On contention the side not served last wins.
    always_comb begin
        state_d = state_q;
        grant   = 1'b0;
        pick_dm = 1'b0;
        unique case (state_q)
            ARB_IDLE: begin
                if (if_req || dm_req) begin
                    grant   = 1'b1;
                    pick_dm = dm_req && (!if_req || !last_dm_q);
                    state_d = ARB_ACCESS;
                end
            end
            ARB_ACCESS: begin
                if (cnt_q == '0) begin
                    state_d = ARB_DONE;
                end
            end
            ARB_DONE: state_d = ARB_IDLE;
            default:  state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            owner_q    <= 1'b0;
            w_q        <= 1'b0;
            last_dm_q  <= 1'b1;
            addr_q     <= '0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
        end else begin
            if (grant) begin
                owner_q <= pick_dm;
                addr_q  <= pick_dm ? dm_addr : if_addr;
                w_q     <= pick_dm & dm_w;
                cnt_q   <= CNT_LOAD;
                if (pick_dm) begin
                    wdata_q <= dm_wdata;
                end
            end
            if (state_q == ARB_ACCESS) begin
                if (cnt_q != '0) begin
                    cnt_q <= cnt_q - 1'b1;
                end else begin
                    last_dm_q <= owner_q;
                    if (!w_q) begin
                        if (owner_q) begin
                            dm_rdata_q <= mem_data_out;
                        end else begin
                            if_rdata_q <= mem_data_out;
                        end
                    end
                end
            end
        end
    end

    assign mem_on      = (state_q == ARB_ACCESS);
    assign mem_w       = mem_on & w_q;
    assign mem_addr    = addr_q;
    assign mem_data_in = wdata_q;
    assign if_done     = (state_q == ARB_DONE) & ~owner_q;
    assign dm_done     = (state_q == ARB_DONE) & owner_q;
    assign if_rdata    = if_rdata_q;
    assign dm_rdata    = dm_rdata_q;
    assign busy        = (state_q != ARB_IDLE);
    assign grant_dm    = owner_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a memory model
// and a scoreboard of expected completions.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_done;
    logic [31:0] if_rdata;
    logic        dm_req = 1'b0;
    logic        dm_w = 1'b0;
    logic [31:0] dm_addr = '0;
    logic [31:0] dm_wdata = '0;
    logic        dm_done;
    logic [31:0] dm_rdata;
    logic        mem_on;
    logic        mem_w;
    logic [31:0] mem_addr;
    logic [31:0] mem_data_in;
    logic [31:0] mem_data_out;
    logic        busy;
    logic        grant_dm;

    typedef struct {
        logic        dm;
        logic [31:0] data;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad = 0;
    int          n_if = 0;
    int          n_dm = 0;
    logic [31:0] mem [0:255];

    mem_port_arbiter #(
        .WORD_SIZE(32),
        .MEM_LATENCY(2)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .if_req(if_req),
        .if_addr(if_addr),
        .if_done(if_done),
        .if_rdata(if_rdata),
        .dm_req(dm_req),
        .dm_w(dm_w),
        .dm_addr(dm_addr),
        .dm_wdata(dm_wdata),
        .dm_done(dm_done),
        .dm_rdata(dm_rdata),
        .mem_on(mem_on),
        .mem_w(mem_w),
        .mem_addr(mem_addr),
        .mem_data_in(mem_data_in),
        .mem_data_out(mem_data_out),
        .busy(busy),
        .grant_dm(grant_dm)
    );

    always #5 clk = ~clk;

    always_comb begin
        mem_data_out = '0;
        if (mem_on) begin
            mem_data_out = mem[mem_addr[9:2]];
        end
    end

    always @(posedge clk) begin
        if (mem_on && mem_w) begin
            mem[mem_addr[9:2]] <= mem_data_in;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && (if_done || dm_done)) begin
            exp_t e;
            if (if_done) n_if++;
            if (dm_done) n_dm++;
            chk("done_onehot", {31'd0, if_done ^ dm_done}, 32'd1);
            chk("sb_nonempty", {31'd0, sb.size() != 0}, 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("sb_side", {31'd0, dm_done}, {31'd0, e.dm});
                chk("sb_rdata", dm_done ? dm_rdata : if_rdata, e.data);
            end
        end
    end

    task automatic push(input logic dm, input logic [31:0] data);
        exp_t e;
        e.dm = dm;
        e.data = data;
        sb.push_back(e);
    endtask

    task automatic wait_on(input string tag);
        bit hit = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (mem_on) begin
                hit = 1;
                break;
            end
        end
        if (!hit) chk(tag, 32'd0, 32'd1);
    endtask

    task automatic wait_done(input string tag, input logic dm);
        bit hit = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (dm ? dm_done : if_done) begin
                hit = 1;
                break;
            end
        end
        if (!hit) chk(tag, 32'd0, 32'd1);
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int d0;
        for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 + i;
        mem[16] = 32'h2008_0005;

        #2;
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_mem_on", {31'd0, mem_on}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_grant", {31'd0, grant_dm}, 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_if_rdata", if_rdata, 32'd0);
        chk("rst_dm_rdata", dm_rdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // single fetch
        if_req = 1'b1;
        if_addr = 32'h40;
        push(1'b0, 32'h2008_0005);
        @(negedge clk);
        chk("f_on1", {31'd0, mem_on}, 32'd1);
        chk("f_addr1", mem_addr, 32'h40);
        chk("f_w1", {31'd0, mem_w}, 32'd0);
        chk("f_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        chk("f_on2", {31'd0, mem_on}, 32'd1);
        chk("f_addr2", mem_addr, 32'h40);
        @(negedge clk);
        chk("f_done", {31'd0, if_done}, 32'd1);
        chk("f_on3", {31'd0, mem_on}, 32'd0);
        if_req = 1'b0;
        @(negedge clk);
        chk("f_idle", {31'd0, busy}, 32'd0);
        chk("f_rdata", if_rdata, 32'h2008_0005);

        // store
        dm_req = 1'b1;
        dm_w = 1'b1;
        dm_addr = 32'h100;
        dm_wdata = 32'hDEAD_BEEF;
        push(1'b1, 32'd0);
        @(negedge clk);
        chk("s_w1", {31'd0, mem_w}, 32'd1);
        chk("s_din1", mem_data_in, 32'hDEAD_BEEF);
        chk("s_addr1", mem_addr, 32'h100);
        chk("s_grant", {31'd0, grant_dm}, 32'd1);
        @(negedge clk);
        chk("s_w2", {31'd0, mem_w}, 32'd1);
        @(negedge clk);
        chk("s_done", {31'd0, dm_done}, 32'd1);
        chk("s_w3", {31'd0, mem_w}, 32'd0);
        dm_req = 1'b0;
        dm_w = 1'b0;
        @(negedge clk);
        chk("s_mem", mem[64], 32'hDEAD_BEEF);
        chk("s_rdata", dm_rdata, 32'd0);

        // simultaneous requests from reset
        do_reset();
        if_addr = 32'h40;
        dm_addr = 32'h80;
        if_req = 1'b1;
        dm_req = 1'b1;
        push(1'b0, 32'h2008_0005);
        push(1'b1, 32'h1000_0020);
        push(1'b0, 32'h2008_0005);
        push(1'b1, 32'h1000_0020);
        for (int k = 0; k < 4; k++) begin
            logic kd;
            kd = (k % 2) == 1;
            wait_on("alt_timeout_on");
            chk("alt_grant", {31'd0, grant_dm}, {31'd0, kd});
            chk("alt_addr", mem_addr, kd ? 32'h80 : 32'h40);
            wait_done("alt_timeout_done", kd);
        end
        if_req = 1'b0;
        dm_req = 1'b0;
        @(negedge clk);

        // mid-access address change
        if_req = 1'b1;
        if_addr = 32'h40;
        push(1'b0, 32'h2008_0005);
        @(negedge clk);
        chk("m_addr1", mem_addr, 32'h40);
        if_addr = 32'h44;
        @(negedge clk);
        chk("m_addr2", mem_addr, 32'h40);
        @(negedge clk);
        chk("m_done", {31'd0, if_done}, 32'd1);
        if_req = 1'b0;
        @(negedge clk);

        // reset during the first mem_on cycle
        if_req = 1'b1;
        if_addr = 32'h48;
        @(negedge clk);
        chk("r_on", {31'd0, mem_on}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("r_mem_on", {31'd0, mem_on}, 32'd0);
        chk("r_busy", {31'd0, busy}, 32'd0);
        chk("r_addr", mem_addr, 32'd0);
        chk("r_if_rdata", if_rdata, 32'd0);
        chk("r_done", {31'd0, if_done}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        push(1'b0, 32'h1000_0012);
        @(negedge clk);
        chk("r_restart_on", {31'd0, mem_on}, 32'd1);
        chk("r_restart_addr", mem_addr, 32'h48);
        wait_done("r_timeout", 1'b0);
        if_req = 1'b0;
        @(negedge clk);
        chk("r_rdata", if_rdata, 32'h1000_0012);

        // load held through DONE then dropped
        d0 = n_dm;
        dm_req = 1'b1;
        dm_w = 1'b0;
        dm_addr = 32'h84;
        push(1'b1, 32'h1000_0021);
        wait_done("l_timeout", 1'b1);
        dm_req = 1'b0;
        repeat (6) @(negedge clk);
        chk("l_once", n_dm - d0, 32'd1);
        chk("l_rdata", dm_rdata, 32'h1000_0021);

        chk("sb_drained", sb.size(), 32'd0);
        chk("n_if", n_if, 32'd5);
        chk("n_dm", n_dm, 32'd4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
